// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions four asynchronous push-button inputs for the control logic. Each
// raw level passes through a two-flop synchroniser. The whole synchronised
// vector is then debounced as a unit. A small event FSM turns each debounced
// single-button press into one press_valid/press_ack handshake. Presses that
// involve more than one button raise a one-cycle multi_err pulse and produce
// no handshake.
//
// Ports
//   clk          in   system clock (100 MHz); the only clock in the block
//   reset        in   asynchronous reset, active low
//   btn_raw      in   [3:0] raw button levels, active high, asynchronous to clk
//   press_ack    in   consumer accepts the pending press
//   btn_clean    out  [3:0] synchronised, debounced button levels
//   press_valid  out  a one-hot press is pending
//   press_val    out  [1:0] index of the pending button; stable while press_valid
//   multi_err    out  one-cycle pulse when more than one button is accepted at once
//   press_count  out  [7:0] count of press_valid rising edges, wraps at 255
//                     (present only when BTN_COND_PRESS_CNT_EN is defined)
//
// Optional feature macro: BTN_COND_PRESS_CNT_EN
//
// Parameter
//   DEBOUNCE_CYCLES  number of consecutive stable cycles needed to accept a
//                    change; the legal range is 1 .. 2^20-1
//
// Event FSM
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no buttons accepted; waiting for btn_clean to go non-zero
//   HOLD     | one-hot press latched; press_valid high until press_ack
//   WAIT_REL | press consumed or rejected; waiting for all buttons released
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       press_ack,
    output logic [3:0] btn_clean,
    output logic       press_valid,
    output logic [1:0] press_val,
    output logic       multi_err
`ifdef BTN_COND_PRESS_CNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int         CNT_W    = 20;
    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Synchroniser and debounce
    // ---------------------------------------------------------------------
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       clean_q, clean_d;
    logic             vec_changed;

    // The stability timer counts down. Any change of the synchronised vector
    // reloads it to DEBOUNCE_CYCLES. When it reaches zero the vector is
    // accepted. It then stays at zero, so a stable vector is re-sampled every
    // cycle without changing btn_clean.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        last_d      = sync2_q;
        vec_changed = (sync2_q != last_q);
        cnt_d       = cnt_q;
        if (vec_changed) begin
            cnt_d = DEB_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        clean_d = clean_q;
        if (cnt_d == '0) begin
            clean_d = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    // ---------------------------------------------------------------------
    // Event FSM
    // ---------------------------------------------------------------------
    logic       clean_onehot;
    logic [1:0] clean_idx;

    always_comb begin
        clean_onehot = 1'b1;
        clean_idx    = 2'd0;
        case (clean_q)
            4'b0001: clean_idx = 2'd0;
            4'b0010: clean_idx = 2'd1;
            4'b0100: clean_idx = 2'd2;
            4'b1000: clean_idx = 2'd3;
            default: clean_onehot = 1'b0;
        endcase
    end

    state_t     state_q, state_d;
    logic       press_valid_q, press_valid_d;
    logic [1:0] press_val_q, press_val_d;
    logic       multi_err_q, multi_err_d;

    always_comb begin
        state_d       = state_q;
        press_valid_d = press_valid_q;
        press_val_d   = press_val_q;
        multi_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clean_onehot) begin
                    press_val_d   = clean_idx;
                    press_valid_d = 1'b1;
                    state_d       = HOLD;
                end else if (clean_q != 4'b0000) begin
                    multi_err_d = 1'b1;
                    state_d     = WAIT_REL;
                end
            end
            HOLD: begin
                // Releases and extra buttons are ignored here. Only the
                // consumer's ack ends the handshake.
                if (press_ack) begin
                    press_valid_d = 1'b0;
                    state_d       = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (clean_q == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                press_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            press_valid_q <= 1'b0;
            press_val_q   <= 2'd0;
            multi_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            press_valid_q <= press_valid_d;
            press_val_q   <= press_val_d;
            multi_err_q   <= multi_err_d;
        end
    end

`ifdef BTN_COND_PRESS_CNT_EN
    // ---------------------------------------------------------------------
    // Press counter
    // ---------------------------------------------------------------------
    logic [7:0] press_count_q, press_count_d;

    // The count advances on the same edge that press_valid rises. The 8-bit
    // width makes it wrap from 255 to 0.
    always_comb begin
        press_count_d = press_count_q;
        if (press_valid_d && !press_valid_q) begin
            press_count_d = press_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count_q <= 8'd0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign press_count = press_count_q;
`endif

    assign btn_clean   = clean_q;
    assign press_valid = press_valid_q;
    assign press_val   = press_val_q;
    assign multi_err   = multi_err_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE_CYCLES=4.
//
// The stimulus pushes each expected press or multi-error event into exp_q.
// Each event carries its button index and the cycle at which it must appear.
// An independent negedge monitor pops the queue whenever the DUT shows a
// press_valid rising edge or a multi_err pulse.
//
// Timing convention: inputs change 1 ns after a posedge, and t0 holds the
// number of posedges seen at that point. The first edge that samples the new
// input is t0+1. btn_clean changes DEBOUNCE_CYCLES+2 edges later, at t0+7.
// press_valid and multi_err appear one edge after that, at t0+8.
module tb_button_conditioner;

    localparam int DEB        = 4;
    localparam int KIND_PRESS = 1;
    localparam int KIND_MULTI = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       press_ack;
    logic [3:0] btn_clean;
    logic       press_valid;
    logic [1:0] press_val;
    logic       multi_err;
`ifdef BTN_COND_PRESS_CNT_EN
    logic [7:0] press_count;
`endif

    button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .press_ack   (press_ack),
        .btn_clean   (btn_clean),
        .press_valid (press_valid),
        .press_val   (press_val),
        .multi_err   (multi_err)
`ifdef BTN_COND_PRESS_CNT_EN
        ,
        .press_count (press_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input int kind, input int val, input int c);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic score(input int kind, input int val);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, 0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor
    logic       pv_prev  = 1'b0;
    logic       me_prev  = 1'b0;
    logic [1:0] held_val = 2'd0;

    always @(negedge clk) begin
        if (press_valid && pv_prev)
            chk("press_val_stable", int'(press_val), int'(held_val));
        if (me_prev)
            chk("multi_err_width", int'(multi_err), 0);
        if (press_valid && !pv_prev) begin
            held_val <= press_val;
            score(KIND_PRESS, int'(press_val));
        end
        if (multi_err && !me_prev)
            score(KIND_MULTI, 0);
        pv_prev <= press_valid;
        me_prev <= multi_err;
    end

    // Stimulus helpers
    int t0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] v);
        @(posedge clk);
        #1;
        btn_raw = v;
        t0      = cyc;
    endtask

    task automatic at_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1;
        chk("pv_before_ack", int'(press_valid), 1);
        press_ack = 1'b1;
        @(posedge clk);
        #1;
        press_ack = 1'b0;
        chk("pv_after_ack", int'(press_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset     = 1'b0;
        btn_raw   = 4'b1111;
        press_ack = 1'b0;

        // Reset state, with buttons held active while reset is low
        tick(3);
        chk("rst_btn_clean", int'(btn_clean), 0);
        chk("rst_press_valid", int'(press_valid), 0);
        chk("rst_press_val", int'(press_val), 0);
        chk("rst_multi_err", int'(multi_err), 0);
        btn_raw = 4'b0000;
        tick(1);
        reset = 1'b1;
        tick(10);
        chk("idle_btn_clean", int'(btn_clean), 0);
        chk("idle_press_valid", int'(press_valid), 0);

        // Single press: latency and hold until ack
        set_btn(4'b0001);
        push_exp(KIND_PRESS, 0, t0 + 8);
        at_neg(t0 + 6);
        chk("clean_before_latency", int'(btn_clean), 0);
        at_neg(t0 + 7);
        chk("clean_latency", int'(btn_clean), 1);
        chk("pv_not_yet", int'(press_valid), 0);
        at_neg(t0 + 8);
        chk("pv_asserted", int'(press_valid), 1);
        at_neg(t0 + 20);
        chk("pv_held", int'(press_valid), 1);
        do_ack();
        set_btn(4'b0000);
        tick(12);

        // Ack with nothing pending is ignored
        press_ack = 1'b1;
        tick(3);
        chk("idle_ack_ignored", int'(press_valid), 0);
        press_ack = 1'b0;

        // Three-cycle glitches never reach btn_clean
        for (int i = 0; i < 4; i++) begin
            set_btn(4'b0100);
            tick(2);
            chk("glitch_clean_hi", int'(btn_clean), 0);
            set_btn(4'b0000);
            tick(2);
            chk("glitch_clean_lo", int'(btn_clean), 0);
        end
        tick(10);
        chk("glitch_final_clean", int'(btn_clean), 0);
        chk("glitch_final_pv", int'(press_valid), 0);

        // Two buttons at once: multi_err pulse and no press
        set_btn(4'b0011);
        push_exp(KIND_MULTI, 0, t0 + 8);
        at_neg(t0 + 7);
        chk("multi_clean", int'(btn_clean), 3);
        at_neg(t0 + 12);
        chk("multi_no_pv", int'(press_valid), 0);
        set_btn(4'b0000);
        tick(12);
        chk("multi_released", int'(btn_clean), 0);
        set_btn(4'b1000);
        push_exp(KIND_PRESS, 3, t0 + 8);
        at_neg(t0 + 9);
        chk("press3_val", int'(press_val), 3);
        do_ack();
        set_btn(4'b0000);
        tick(12);

        // Extra buttons during HOLD and WAIT_REL change nothing
        set_btn(4'b0001);
        push_exp(KIND_PRESS, 0, t0 + 8);
        at_neg(t0 + 10);
        set_btn(4'b0101);
        at_neg(t0 + 8);
        chk("extra_clean", int'(btn_clean), 5);
        chk("extra_val", int'(press_val), 0);
        do_ack();
        tick(5);
        chk("extra_wait_pv", int'(press_valid), 0);
        set_btn(4'b0100);
        tick(12);
        chk("extra_partial_pv", int'(press_valid), 0);
        set_btn(4'b0000);
        tick(12);

        // Release before ack, then ack 20 cycles later
        set_btn(4'b0010);
        p0 = t0;
        push_exp(KIND_PRESS, 1, p0 + 8);
        at_neg(p0 + 8);
        set_btn(4'b0000);
        at_neg(p0 + 28);
        chk("rel_before_ack_pv", int'(press_valid), 1);
        chk("rel_before_ack_val", int'(press_val), 1);
        do_ack();
        tick(15);
        chk("rel_no_second_press", int'(press_valid), 0);

        // Reset during HOLD with the button still held
        set_btn(4'b0001);
        push_exp(KIND_PRESS, 0, t0 + 8);
        at_neg(t0 + 10);
        chk("pre_reset_pv", int'(press_valid), 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_pv", int'(press_valid), 0);
        chk("async_reset_clean", int'(btn_clean), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        t0    = cyc;
        push_exp(KIND_PRESS, 0, t0 + 8);
        at_neg(t0 + 7);
        chk("post_reset_pv_not_yet", int'(press_valid), 0);
        at_neg(t0 + 8);
        chk("post_reset_pv", int'(press_valid), 1);
        do_ack();
        set_btn(4'b0000);
        tick(12);

`ifdef BTN_COND_PRESS_CNT_EN
        chk("press_count_start", int'(press_count), 1);
        for (int i = 0; i < 255; i++) begin
            set_btn(4'b0001);
            push_exp(KIND_PRESS, 0, t0 + 8);
            at_neg(t0 + 8);
            do_ack();
            set_btn(4'b0000);
            tick(8);
        end
        chk("press_count_wrap", int'(press_count), 0);
`endif

        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk cycles required to accept a button change (10 ms at 100 MHz); legal range 1..2^20-1.
REQ-002 Port clk  input  1  100 MHz system clock; the only clock in the block.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port btn_raw  input  4  raw push-button levels, asynchronous to clk, active-high.
REQ-005 Port press_ack  input  1  consumer accepts the pending press.
REQ-006 Port btn_clean  output  4  synchronised, debounced button levels.
REQ-007 Port press_valid  output  1  a one-hot press is pending.
REQ-008 Port press_val  output  2  index of the pending button (bit0->0 ... bit3->3); stable while press_valid=1.
REQ-009 Port multi_err  output  1  one-cycle pulse when more than one button is accepted at once.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchroniser per bit before any other use.
REQ-011 Debounce SHALL operate on the whole 4-bit synchronised vector; any change of that vector SHALL clear the stability counter.
REQ-012 btn_clean SHALL take the synchronised value on the cycle in which the vector has been unchanged for DEBOUNCE_CYCLES consecutive cycles; counter saturates (no wrap) once accepted.
REQ-013 Latency: a raw change held stable SHALL appear on btn_clean exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES SHALL never reach btn_clean.
REQ-015 Event FSM states: IDLE, HOLD, WAIT_REL.
REQ-016 IDLE: btn_clean one-hot -> latch press_val, press_valid=1 next cycle, go HOLD; btn_clean nonzero non-one-hot -> multi_err=1 for one cycle, go WAIT_REL; btn_clean=0 -> stay.
REQ-017 HOLD: press_valid held at 1 until a cycle with press_ack=1; press_valid=0 the following cycle, go WAIT_REL.
REQ-018 press_ack while press_valid=0 SHALL be ignored.
REQ-019 WAIT_REL: go IDLE on the first cycle btn_clean=0; no new press or multi_err is generated until then.
REQ-020 Release before ack: press_valid SHALL remain 1 until ack; WAIT_REL then exits after one cycle.
REQ-021 Additional buttons pressed during HOLD/WAIT_REL SHALL NOT change press_val or raise multi_err.
REQ-022 Exactly one press_valid assertion per debounced press-release cycle.

Reset
REQ-023 reset=0 SHALL asynchronously clear synchroniser flops, counter, btn_clean=0, press_valid=0, press_val=0, multi_err=0, FSM=IDLE.
REQ-024 Reset asserted mid-HOLD SHALL drop press_valid immediately; the pending press is discarded.
REQ-025 After reset release, a button already held SHALL be treated as a new press once debounced.

Configuration
REQ-026 Macro BTN_COND_PRESS_CNT_EN defined: adds output press_count (8 bits), incremented on each press_valid rising edge, wraps 255->0, reset to 0.
REQ-027 Macro BTN_COND_PRESS_CNT_EN undefined: no press_count port and no counter logic; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 btn_raw=0001 held -> btn_clean=0001 at cycle 6, press_valid=1, press_val=0 at cycle 7; held until press_ack.
REQ-029 btn_raw=0100 toggled 3-cycle pulses -> btn_clean stays 0000, press_valid never asserts.
REQ-030 btn_raw=0011 held -> multi_err single-cycle pulse, press_valid stays 0; release then 1000 -> press_val=3.
REQ-031 btn_raw=0010 pressed and released before ack, press_ack after 20 cycles -> press_valid 1 until ack cycle, 0 next; no second press.
REQ-032 reset pulled low during HOLD -> press_valid=0 asynchronously; with button still held, new press_valid after DEBOUNCE_CYCLES+3 cycles.
REQ-033 With BTN_COND_PRESS_CNT_EN: 256 clean presses -> press_count returns to 0.
